// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - icache/dcache arbiter for the shared L2 request port
// Round-robin on ties, grant held until L2 fulfils, saturating perf counters.
module l2_port_arbiter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  ic_req_address,
  input  logic             ic_req_valid,
  output logic [XLEN-1:0]  ic_fetched_word,
  output logic             ic_req_fulfilled,
  input  logic [XLEN-1:0]  dc_req_address,
  input  logic             dc_req_type,
  input  logic             dc_req_valid,
  input  logic [XLEN-1:0]  dc_word_to_store,
  output logic [XLEN-1:0]  dc_fetched_word,
  output logic             dc_req_fulfilled,
  output logic [XLEN-1:0]  l2_req_address,
  output logic             l2_req_type,
  output logic             l2_req_valid,
  output logic [XLEN-1:0]  l2_word_to_store,
  input  logic [XLEN-1:0]  l2_fetched_word,
  input  logic             l2_req_fulfilled,
  output logic [1:0]       grant_owner,
  output logic [CNT_W-1:0] ic_grant_count,
  output logic [CNT_W-1:0] dc_grant_count,
  output logic [CNT_W-1:0] contention_count
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] OWN_I = 2'b01;
  localparam logic [1:0] OWN_D = 2'b10;

  localparam logic OP_LOAD = 1'b0;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       last_dc;
  logic       next_last_dc;
  logic       take_ic;
  logic       take_dc;
  logic       contend;

  always_comb begin
    l2_req_address   = '0;
    l2_req_type      = OP_LOAD;
    l2_req_valid     = 1'b0;
    l2_word_to_store = '0;
    ic_fetched_word  = '0;
    ic_req_fulfilled = 1'b0;
    dc_fetched_word  = '0;
    dc_req_fulfilled = 1'b0;
    case (state)
      OWN_I: begin
        l2_req_address   = ic_req_address;
        l2_req_valid     = ic_req_valid;
        ic_fetched_word  = l2_fetched_word;
        ic_req_fulfilled = l2_req_fulfilled & ic_req_valid;
      end
      OWN_D: begin
        l2_req_address   = dc_req_address;
        l2_req_type      = dc_req_type;
        l2_req_valid     = dc_req_valid;
        l2_word_to_store = dc_word_to_store;
        dc_fetched_word  = l2_fetched_word;
        dc_req_fulfilled = l2_req_fulfilled & dc_req_valid;
      end
      default: ;
    endcase
  end

  assign grant_owner = state;

  // Completion hands the port straight to a waiting peer; otherwise fall back to IDLE.
  always_comb begin
    take_ic      = 1'b0;
    take_dc      = 1'b0;
    contend      = 1'b0;
    next_last_dc = last_dc;
    next_state   = state;
    case (state)
      IDLE: begin
        if (ic_req_valid && dc_req_valid) begin
          contend = 1'b1;
          if (last_dc) take_ic = 1'b1;
          else         take_dc = 1'b1;
        end else if (ic_req_valid) begin
          take_ic = 1'b1;
        end else if (dc_req_valid) begin
          take_dc = 1'b1;
        end
      end
      OWN_I: begin
        if (ic_req_fulfilled) begin
          next_last_dc = 1'b0;
          if (dc_req_valid) take_dc = 1'b1;
          else              next_state = IDLE;
        end else if (!ic_req_valid) begin
          next_state = IDLE;
        end
      end
      OWN_D: begin
        if (dc_req_fulfilled) begin
          next_last_dc = 1'b1;
          if (ic_req_valid) take_ic = 1'b1;
          else              next_state = IDLE;
        end else if (!dc_req_valid) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (take_ic) next_state = OWN_I;
    if (take_dc) next_state = OWN_D;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      last_dc          <= 1'b0;
      ic_grant_count   <= '0;
      dc_grant_count   <= '0;
      contention_count <= '0;
    end else begin
      state   <= next_state;
      last_dc <= next_last_dc;
      if (take_ic && ic_grant_count != CNT_MAX)
        ic_grant_count <= ic_grant_count + CNT_ONE;
      if (take_dc && dc_grant_count != CNT_MAX)
        dc_grant_count <= dc_grant_count + CNT_ONE;
      if (contend && contention_count != CNT_MAX)
        contention_count <= contention_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb/tb_l2_port_arbiter.sv - directed bench for l2_port_arbiter
module tb_l2_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ic_req_address = '0;
  logic        ic_req_valid = 1'b0;
  logic [31:0] ic_fetched_word;
  logic        ic_req_fulfilled;
  logic [31:0] dc_req_address = '0;
  logic        dc_req_type = 1'b0;
  logic        dc_req_valid = 1'b0;
  logic [31:0] dc_word_to_store = '0;
  logic [31:0] dc_fetched_word;
  logic        dc_req_fulfilled;
  logic [31:0] l2_req_address;
  logic        l2_req_type;
  logic        l2_req_valid;
  logic [31:0] l2_word_to_store;
  logic [31:0] l2_fetched_word = '0;
  logic        l2_req_fulfilled = 1'b0;
  logic [1:0]  grant_owner;
  logic [15:0] ic_grant_count;
  logic [15:0] dc_grant_count;
  logic [15:0] contention_count;

  logic        s_ic_valid = 1'b0;
  logic        s_fulfilled = 1'b0;
  logic [31:0] s_ic_fetched_word;
  logic        s_ic_req_fulfilled;
  logic [31:0] s_dc_fetched_word;
  logic        s_dc_req_fulfilled;
  logic [31:0] s_l2_req_address;
  logic        s_l2_req_type;
  logic        s_l2_req_valid;
  logic [31:0] s_l2_word_to_store;
  logic [1:0]  s_grant_owner;
  logic [1:0]  s_ic_grant_count;
  logic [1:0]  s_dc_grant_count;
  logic [1:0]  s_contention_count;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  l2_port_arbiter #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .ic_req_address(ic_req_address), .ic_req_valid(ic_req_valid),
    .ic_fetched_word(ic_fetched_word), .ic_req_fulfilled(ic_req_fulfilled),
    .dc_req_address(dc_req_address), .dc_req_type(dc_req_type),
    .dc_req_valid(dc_req_valid), .dc_word_to_store(dc_word_to_store),
    .dc_fetched_word(dc_fetched_word), .dc_req_fulfilled(dc_req_fulfilled),
    .l2_req_address(l2_req_address), .l2_req_type(l2_req_type),
    .l2_req_valid(l2_req_valid), .l2_word_to_store(l2_word_to_store),
    .l2_fetched_word(l2_fetched_word), .l2_req_fulfilled(l2_req_fulfilled),
    .grant_owner(grant_owner), .ic_grant_count(ic_grant_count),
    .dc_grant_count(dc_grant_count), .contention_count(contention_count)
  );

  l2_port_arbiter #(.XLEN(32), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset),
    .ic_req_address(32'h0000_0100), .ic_req_valid(s_ic_valid),
    .ic_fetched_word(s_ic_fetched_word), .ic_req_fulfilled(s_ic_req_fulfilled),
    .dc_req_address(32'h0), .dc_req_type(1'b0),
    .dc_req_valid(1'b0), .dc_word_to_store(32'h0),
    .dc_fetched_word(s_dc_fetched_word), .dc_req_fulfilled(s_dc_req_fulfilled),
    .l2_req_address(s_l2_req_address), .l2_req_type(s_l2_req_type),
    .l2_req_valid(s_l2_req_valid), .l2_word_to_store(s_l2_word_to_store),
    .l2_fetched_word(32'h5555_AAAA), .l2_req_fulfilled(s_fulfilled),
    .grant_owner(s_grant_owner), .ic_grant_count(s_ic_grant_count),
    .dc_grant_count(s_dc_grant_count), .contention_count(s_contention_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_req_valid = 1'b0; dc_req_valid = 1'b0; l2_req_fulfilled = 1'b0;
    dc_req_type = 1'b0; dc_word_to_store = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ic_req_valid = 1'b1; dc_req_valid = 1'b1; l2_req_fulfilled = 1'b1;
    l2_fetched_word = 32'hFFFF_FFFF;
    repeat (3) step();
    ic_req_valid = 1'b0;
    step();
    ic_req_valid = 1'b1;
    #2;
    total++; if (l2_req_valid !== 1'b0) $display("FAIL rst_l2_valid: got %0h want 0", l2_req_valid); else passed++;
    total++; if (grant_owner !== 2'b00) $display("FAIL rst_owner: got %0h want 0", grant_owner); else passed++;
    total++; if (ic_grant_count !== 16'd0 || dc_grant_count !== 16'd0 || contention_count !== 16'd0)
      $display("FAIL rst_counts: got %0h/%0h/%0h want 0/0/0", ic_grant_count, dc_grant_count, contention_count); else passed++;
    total++; if (ic_req_fulfilled !== 1'b0 || dc_req_fulfilled !== 1'b0)
      $display("FAIL rst_fulfilled: got %0h/%0h want 0/0", ic_req_fulfilled, dc_req_fulfilled); else passed++;
    total++; if (ic_fetched_word !== 32'h0 || dc_fetched_word !== 32'h0 || l2_req_type !== 1'b0)
      $display("FAIL rst_words: got %0h/%0h type %0h want 0", ic_fetched_word, dc_fetched_word, l2_req_type); else passed++;
    clear_inputs();
    reset = 1'b1;
    step();
  endtask

  task automatic test_lone_dc();
    dc_req_valid = 1'b1; dc_req_type = 1'b0; dc_req_address = 32'h0000_1230;
    l2_req_fulfilled = 1'b1; l2_fetched_word = 32'hCAFE_0001;
    #2;
    total++; if (l2_req_valid !== 1'b0 || dc_req_fulfilled !== 1'b0)
      $display("FAIL lone_idle: got valid %0h ful %0h want 0/0", l2_req_valid, dc_req_fulfilled); else passed++;
    step();
    total++; if (grant_owner !== 2'b10) $display("FAIL lone_owner: got %0h want 2", grant_owner); else passed++;
    total++; if (l2_req_address !== 32'h0000_1230 || l2_req_valid !== 1'b1)
      $display("FAIL lone_l2_req: got %0h/%0h want 1230/1", l2_req_address, l2_req_valid); else passed++;
    total++; if (dc_req_fulfilled !== 1'b1 || dc_fetched_word !== 32'hCAFE_0001 || ic_fetched_word !== 32'h0)
      $display("FAIL lone_data: got %0h/%0h/%0h want 1/cafe0001/0", dc_req_fulfilled, dc_fetched_word, ic_fetched_word); else passed++;
    total++; if (dc_grant_count !== 16'd1) $display("FAIL lone_dc_count: got %0d want 1", dc_grant_count); else passed++;
    step();
    clear_inputs();
    #2;
    total++; if (grant_owner !== 2'b00) $display("FAIL lone_back_idle: got %0h want 0", grant_owner); else passed++;
  endtask

  task automatic test_abort();
    ic_req_valid = 1'b1; ic_req_address = 32'h0000_0080;
    step();
    total++; if (grant_owner !== 2'b01 || ic_grant_count !== 16'd1)
      $display("FAIL abort_grant: got owner %0h cnt %0d want 1/1", grant_owner, ic_grant_count); else passed++;
    ic_req_valid = 1'b0; l2_req_fulfilled = 1'b1;
    #2;
    total++; if (ic_req_fulfilled !== 1'b0 || l2_req_valid !== 1'b0)
      $display("FAIL abort_no_pulse: got ful %0h valid %0h want 0/0", ic_req_fulfilled, l2_req_valid); else passed++;
    step();
    l2_req_fulfilled = 1'b0;
    #2;
    total++; if (grant_owner !== 2'b00 || ic_grant_count !== 16'd1)
      $display("FAIL abort_idle: got owner %0h cnt %0d want 0/1", grant_owner, ic_grant_count); else passed++;
    ic_req_valid = 1'b1; dc_req_valid = 1'b1;
    step();
    total++; if (grant_owner !== 2'b01) $display("FAIL abort_last_owner: got %0h want 1", grant_owner); else passed++;
    clear_inputs();
    step();
  endtask

  task automatic test_tie();
    do_reset();
    ic_req_valid = 1'b1; dc_req_valid = 1'b1; l2_fetched_word = 32'h0BAD_F00D;
    step();
    total++; if (grant_owner !== 2'b10 || contention_count !== 16'd1)
      $display("FAIL tie_first: got owner %0h cont %0d want 2/1", grant_owner, contention_count); else passed++;
    l2_req_fulfilled = 1'b1;
    #2;
    total++; if (dc_req_fulfilled !== 1'b1 || ic_req_fulfilled !== 1'b0)
      $display("FAIL tie_dc_ful: got dc %0h ic %0h want 1/0", dc_req_fulfilled, ic_req_fulfilled); else passed++;
    step();
    dc_req_valid = 1'b0; l2_req_fulfilled = 1'b0;
    #2;
    total++; if (grant_owner !== 2'b01 || l2_req_valid !== 1'b1 || contention_count !== 16'd1)
      $display("FAIL tie_second: got owner %0h valid %0h cont %0d want 1/1/1", grant_owner, l2_req_valid, contention_count); else passed++;
    l2_req_fulfilled = 1'b1;
    #2;
    total++; if (ic_req_fulfilled !== 1'b1 || ic_fetched_word !== 32'h0BAD_F00D || dc_req_fulfilled !== 1'b0)
      $display("FAIL tie_ic_ful: got %0h/%0h/%0h want 1/badf00d/0", ic_req_fulfilled, ic_fetched_word, dc_req_fulfilled); else passed++;
    step();
    clear_inputs();
    #2;
    total++; if (grant_owner !== 2'b00 || ic_grant_count !== 16'd1 || dc_grant_count !== 16'd1)
      $display("FAIL tie_end: got owner %0h cnt %0d/%0d want 0/1/1", grant_owner, ic_grant_count, dc_grant_count); else passed++;
  endtask

  task automatic test_alternation();
    logic [1:0] exp_owner;
    int errs;
    do_reset();
    errs = 0;
    ic_req_valid = 1'b1; dc_req_valid = 1'b1; l2_req_fulfilled = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_owner = (k % 2 == 1) ? 2'b10 : 2'b01;
      if (grant_owner !== exp_owner) begin
        $display("FAIL alt_owner_%0d: got %0h want %0h", k, grant_owner, exp_owner);
        errs++;
      end
    end
    total++; if (errs == 0) passed++;
    total++; if (ic_grant_count !== 16'd4 || dc_grant_count !== 16'd4)
      $display("FAIL alt_counts: got %0d/%0d want 4/4", ic_grant_count, dc_grant_count); else passed++;
    dc_req_valid = 1'b0;
    step();
    clear_inputs();
    #2;
    total++; if (grant_owner !== 2'b00 || contention_count !== 16'd1)
      $display("FAIL alt_end: got owner %0h cont %0d want 0/1", grant_owner, contention_count); else passed++;
  endtask

  task automatic test_store();
    ic_req_valid = 1'b1; ic_req_address = 32'h0000_0100;
    dc_req_valid = 1'b1; dc_req_type = 1'b1; dc_req_address = 32'h0000_0040;
    dc_word_to_store = 32'hDEAD_BEEF;
    step();
    total++; if (l2_req_type !== 1'b1 || l2_word_to_store !== 32'hDEAD_BEEF || l2_req_address !== 32'h40)
      $display("FAIL store_mux: got type %0h data %0h addr %0h want 1/deadbeef/40", l2_req_type, l2_word_to_store, l2_req_address); else passed++;
    total++; if (ic_req_fulfilled !== 1'b0 || contention_count !== 16'd2)
      $display("FAIL store_ic_wait: got ful %0h cont %0d want 0/2", ic_req_fulfilled, contention_count); else passed++;
    l2_req_fulfilled = 1'b1;
    #2;
    total++; if (dc_req_fulfilled !== 1'b1 || ic_req_fulfilled !== 1'b0)
      $display("FAIL store_ful: got dc %0h ic %0h want 1/0", dc_req_fulfilled, ic_req_fulfilled); else passed++;
    step();
    dc_req_valid = 1'b0; dc_req_type = 1'b0; l2_req_fulfilled = 1'b0;
    #2;
    total++; if (grant_owner !== 2'b01 || l2_req_type !== 1'b0 || l2_req_address !== 32'h100 || l2_word_to_store !== 32'h0)
      $display("FAIL store_ic_turn: got %0h/%0h/%0h/%0h want 1/0/100/0", grant_owner, l2_req_type, l2_req_address, l2_word_to_store); else passed++;
    l2_req_fulfilled = 1'b1;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_saturation();
    s_ic_valid = 1'b1; s_fulfilled = 1'b1;
    repeat (3) step();
    total++; if (s_ic_grant_count !== 2'd2) $display("FAIL sat_mid: got %0d want 2", s_ic_grant_count); else passed++;
    repeat (7) step();
    total++; if (s_ic_grant_count !== 2'd3) $display("FAIL sat_clamp: got %0d want 3", s_ic_grant_count); else passed++;
    s_ic_valid = 1'b0; s_fulfilled = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    dc_req_valid = 1'b1; dc_req_address = 32'h0000_2000;
    l2_req_fulfilled = 1'b1; l2_fetched_word = 32'h1234_5678;
    step();
    total++; if (dc_req_fulfilled !== 1'b1 || grant_owner !== 2'b10)
      $display("FAIL mid_pre: got ful %0h owner %0h want 1/2", dc_req_fulfilled, grant_owner); else passed++;
    #1;
    reset = 1'b0;
    #1;
    total++; if (grant_owner !== 2'b00 || l2_req_valid !== 1'b0 || dc_req_fulfilled !== 1'b0)
      $display("FAIL mid_ctrl: got owner %0h valid %0h ful %0h want 0/0/0", grant_owner, l2_req_valid, dc_req_fulfilled); else passed++;
    total++; if (dc_fetched_word !== 32'h0 || l2_req_address !== 32'h0 || dc_grant_count !== 16'd0)
      $display("FAIL mid_data: got %0h/%0h/%0d want 0/0/0", dc_fetched_word, l2_req_address, dc_grant_count); else passed++;
    clear_inputs();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_lone_dc();
    test_abort();
    test_tie();
    test_alternation();
    test_store();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
